// File: rtl/wb_retire_stage_if.sv
// MEM -> WB bundle for the write-back / retirement stage.
// master: the MEM-side driver (pipeline control plus MEM outputs).
// slave:  the write-back stage itself.
interface wb_retire_stage_if #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_REGS = 5,
    parameter int CNT_BITS  = 32
);
    localparam int LANE_BITS = $clog2(BITS_SIZE / 8);

    // Pipeline control
    logic                  i_stall;
    logic                  i_flush;

    // MEM stage outputs
    logic                  i_mem_valid;
    logic                  i_mem_reg_write;
    logic                  i_mem_mem_to_reg;
    logic                  i_mem_lui;
    logic                  i_mem_jal;
    logic                  i_mem_jalr;
    logic                  i_mem_halt;
    logic                  i_mem_zero_extend;
    logic [1:0]            i_mem_load_size;
    logic [LANE_BITS-1:0]  i_mem_addr_lsb;
    logic [BITS_SIZE-1:0]  i_mem_dato_mem;
    logic [BITS_SIZE-1:0]  i_mem_alu;
    logic [BITS_SIZE-1:0]  i_mem_extension;
    logic [BITS_SIZE-1:0]  i_mem_pc8;
    logic [BITS_REGS-1:0]  i_mem_register_dst;

    // Write-back results
    logic                  o_wb_reg_write;
    logic [BITS_SIZE-1:0]  o_wb_data_write;
    logic [BITS_REGS-1:0]  o_wb_register_adrr_result;
    logic [BITS_SIZE-1:0]  o_wb_data_write_ex;
    logic [CNT_BITS-1:0]   o_retired_count;
    logic                  o_halted;

    modport master (
        output i_stall, i_flush,
        output i_mem_valid, i_mem_reg_write, i_mem_mem_to_reg, i_mem_lui,
        output i_mem_jal, i_mem_jalr, i_mem_halt, i_mem_zero_extend,
        output i_mem_load_size, i_mem_addr_lsb, i_mem_dato_mem, i_mem_alu,
        output i_mem_extension, i_mem_pc8, i_mem_register_dst,
        input  o_wb_reg_write, o_wb_data_write, o_wb_register_adrr_result,
        input  o_wb_data_write_ex, o_retired_count, o_halted
    );

    modport slave (
        input  i_stall, i_flush,
        input  i_mem_valid, i_mem_reg_write, i_mem_mem_to_reg, i_mem_lui,
        input  i_mem_jal, i_mem_jalr, i_mem_halt, i_mem_zero_extend,
        input  i_mem_load_size, i_mem_addr_lsb, i_mem_dato_mem, i_mem_alu,
        input  i_mem_extension, i_mem_pc8, i_mem_register_dst,
        output o_wb_reg_write, o_wb_data_write, o_wb_register_adrr_result,
        output o_wb_data_write_ex, o_retired_count, o_halted
    );
endinterface

// File: rtl/wb_retire_stage.sv
// Write-back / retirement stage of the pipelined MIPS core.
// Holds the MEM/WB register (stall/flush), aligns loads by byte lane,
// builds LUI and link values, counts retired instructions and freezes
// retirement once a HALT reaches write-back.
module wb_retire_stage #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_REGS = 5,
    parameter int LINK_REG  = 31,
    parameter int CNT_BITS  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    wb_retire_stage_if.slave  wb
);
    localparam int LANE_BITS = $clog2(BITS_SIZE / 8);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 lui;
        logic                 jal;
        logic                 jalr;
        logic                 halt;
        logic                 zero_extend;
        logic [1:0]           load_size;
        logic [LANE_BITS-1:0] addr_lsb;
        logic [BITS_SIZE-1:0] dato;
        logic [BITS_SIZE-1:0] alu;
        logic [BITS_SIZE-1:0] extension;
        logic [BITS_SIZE-1:0] pc8;
        logic [BITS_REGS-1:0] register_dst;
    } entry_t;

    entry_t               entry_q, entry_d, mem_entry;
    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 freeze;

    logic [BITS_SIZE-1:0] byte_shift, half_shift, filtered;
    logic [BITS_SIZE-1:0] lui_value, data_to_reg, data_ex;
    logic [BITS_REGS-1:0] wb_addr;
    logic [LANE_BITS-1:0] half_lsb;
    logic signed [7:0]    lane_byte;
    logic signed [15:0]   lane_half;

    // Gather the MEM outputs into one entry for capture.
    always_comb begin
        mem_entry              = '0;
        mem_entry.valid        = wb.i_mem_valid;
        mem_entry.reg_write    = wb.i_mem_reg_write;
        mem_entry.mem_to_reg   = wb.i_mem_mem_to_reg;
        mem_entry.lui          = wb.i_mem_lui;
        mem_entry.jal          = wb.i_mem_jal;
        mem_entry.jalr         = wb.i_mem_jalr;
        mem_entry.halt         = wb.i_mem_halt;
        mem_entry.zero_extend  = wb.i_mem_zero_extend;
        mem_entry.load_size    = wb.i_mem_load_size;
        mem_entry.addr_lsb     = wb.i_mem_addr_lsb;
        mem_entry.dato         = wb.i_mem_dato_mem;
        mem_entry.alu          = wb.i_mem_alu;
        mem_entry.extension    = wb.i_mem_extension;
        mem_entry.pc8          = wb.i_mem_pc8;
        mem_entry.register_dst = wb.i_mem_register_dst;
    end

    // MEM/WB register next state and retirement count.
    // A registered valid HALT already blocks the following load, so the
    // instruction behind a HALT never retires.
    always_comb begin
        freeze  = (state_q == HALTED) || (entry_q.valid && entry_q.halt);
        entry_d = entry_q;
        count_d = count_q;
        if (wb.i_flush) begin
            entry_d = '0;
        end else if (wb.i_stall) begin
            entry_d = entry_q;
        end else if (freeze) begin
            entry_d = '0;
        end else begin
            entry_d = mem_entry;
            if (wb.i_mem_valid) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Halt FSM next state: only reset leaves HALTED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (entry_q.valid && entry_q.halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            entry_q <= '0;
            state_q <= RUN;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Load alignment: pick the addressed lane and extend it.
    always_comb begin
        half_lsb   = {entry_q.addr_lsb[LANE_BITS-1:1], 1'b0};
        byte_shift = entry_q.dato >> {entry_q.addr_lsb, 3'b000};
        half_shift = entry_q.dato >> {half_lsb, 3'b000};
        lane_byte  = byte_shift[7:0];
        lane_half  = half_shift[15:0];
        case (entry_q.load_size)
            2'b00: filtered = entry_q.zero_extend
                            ? {{(BITS_SIZE-8){1'b0}}, lane_byte}
                            : {{(BITS_SIZE-8){lane_byte[7]}}, lane_byte};
            2'b01: filtered = entry_q.zero_extend
                            ? {{(BITS_SIZE-16){1'b0}}, lane_half}
                            : {{(BITS_SIZE-16){lane_half[15]}}, lane_half};
            default: filtered = entry_q.dato;
        endcase
    end

    // Result select, write address and write enable.
    always_comb begin
        lui_value   = (entry_q.extension & BITS_SIZE'(16'hFFFF)) << 16;
        data_to_reg = entry_q.mem_to_reg ? filtered : entry_q.alu;
        data_ex     = entry_q.lui ? lui_value : data_to_reg;
        wb_addr     = entry_q.jal ? BITS_REGS'(LINK_REG) : entry_q.register_dst;

        wb.o_wb_data_write_ex        = data_ex;
        wb.o_wb_data_write           = (entry_q.jal || entry_q.jalr) ? entry_q.pc8 : data_ex;
        wb.o_wb_register_adrr_result = wb_addr;
        wb.o_wb_reg_write            = entry_q.valid
                                     && (entry_q.reg_write || entry_q.jal || entry_q.jalr)
                                     && (wb_addr != '0);
        wb.o_retired_count           = count_q;
        wb.o_halted                  = (state_q == HALTED);
    end
endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: directed instruction vectors, an abstract
// reference model compared every cycle, and literal spot checks.
module tb_wb_retire_stage;
    localparam int BS = 32;
    localparam int BR = 5;
    localparam int CB = 32;
    localparam int LR = 31;

    typedef struct {
        bit        valid, reg_write, mem_to_reg, lui, jal, jalr, halt, zext;
        bit [1:0]  size;
        bit [1:0]  lsb;
        bit [31:0] dato, alu, ext, pc8;
        bit [4:0]  dst;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_retire_stage_if #(.BITS_SIZE(BS), .BITS_REGS(BR), .CNT_BITS(CB)) bus ();

    wb_retire_stage #(.BITS_SIZE(BS), .BITS_REGS(BR), .LINK_REG(LR), .CNT_BITS(CB)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    instr_t cur;
    instr_t nop;

    // Reference model state
    instr_t      m_e;
    bit          m_halted;
    int unsigned m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input instr_t t);
        cur                     = t;
        bus.i_mem_valid         = t.valid;
        bus.i_mem_reg_write     = t.reg_write;
        bus.i_mem_mem_to_reg    = t.mem_to_reg;
        bus.i_mem_lui           = t.lui;
        bus.i_mem_jal           = t.jal;
        bus.i_mem_jalr          = t.jalr;
        bus.i_mem_halt          = t.halt;
        bus.i_mem_zero_extend   = t.zext;
        bus.i_mem_load_size     = t.size;
        bus.i_mem_addr_lsb      = t.lsb;
        bus.i_mem_dato_mem      = t.dato;
        bus.i_mem_alu           = t.alu;
        bus.i_mem_extension     = t.ext;
        bus.i_mem_pc8           = t.pc8;
        bus.i_mem_register_dst  = t.dst;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Loaded value computed with plain arithmetic on the selected lane.
    function automatic logic [31:0] m_load(input instr_t e);
        logic [31:0] v;
        case (e.size)
            2'd0: begin
                v = (e.dato >> (8 * e.lsb)) & 32'hFF;
                if (!e.zext && v >= 32'h80) v = v - 32'h100;
            end
            2'd1: begin
                v = (e.dato >> (16 * (e.lsb / 2))) & 32'hFFFF;
                if (!e.zext && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = e.dato;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_ex(input instr_t e);
        if (e.lui) return (e.ext & 32'hFFFF) * 32'd65536;
        return e.mem_to_reg ? m_load(e) : e.alu;
    endfunction

    function automatic logic [31:0] m_data(input instr_t e);
        return (e.jal || e.jalr) ? e.pc8 : m_ex(e);
    endfunction

    function automatic logic [4:0] m_addr(input instr_t e);
        return e.jal ? 5'(LR) : e.dst;
    endfunction

    function automatic logic m_we(input instr_t e);
        return e.valid && (e.reg_write || e.jal || e.jalr) && (m_addr(e) != 5'd0);
    endfunction

    // Model update: what the write-back register holds after each edge.
    always @(posedge clk) begin
        bit blocked;
        if (rst) begin
            m_e      = nop;
            m_halted = 1'b0;
            m_count  = 0;
        end else begin
            blocked = m_halted || (m_e.valid && m_e.halt);
            if (bus.i_flush)      m_e = nop;
            else if (bus.i_stall) m_e = m_e;
            else if (blocked)     m_e = nop;
            else begin
                m_e = cur;
                if (cur.valid) m_count = m_count + 1;
            end
            m_halted = blocked;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_reg_write", 32'(bus.o_wb_reg_write), 32'(m_we(m_e)));
            check("cyc_addr", 32'(bus.o_wb_register_adrr_result), 32'(m_addr(m_e)));
            check("cyc_halted", 32'(bus.o_halted), 32'(m_halted));
            check("cyc_count", bus.o_retired_count, m_count);
            if (m_e.valid) begin
                check("cyc_data", bus.o_wb_data_write, m_data(m_e));
                check("cyc_data_ex", bus.o_wb_data_write_ex, m_ex(m_e));
            end
        end
    end

    initial begin
        instr_t t;
        nop = '{default: '0};
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(nop);
        rst = 1'b1;
        cycle();
        cycle();
        cmp_en = 1'b1;

        // Reset state
        check("rst_reg_write", 32'(bus.o_wb_reg_write), 32'd0);
        check("rst_data", bus.o_wb_data_write, 32'd0);
        check("rst_data_ex", bus.o_wb_data_write_ex, 32'd0);
        check("rst_addr", 32'(bus.o_wb_register_adrr_result), 32'd0);
        check("rst_count", bus.o_retired_count, 32'd0);
        check("rst_halted", 32'(bus.o_halted), 32'd0);
        rst = 1'b0;

        // Loads from 0x80FF7F01
        t = nop; t.valid = 1; t.reg_write = 1; t.mem_to_reg = 1; t.dato = 32'h80FF7F01; t.dst = 5'd3;
        t.size = 2'd0; t.lsb = 2'd2; t.zext = 0; drive(t); cycle();
        check("lb_lane2", bus.o_wb_data_write, 32'hFFFFFFFF);
        check("lb_addr", 32'(bus.o_wb_register_adrr_result), 32'd3);
        check("lb_we", 32'(bus.o_wb_reg_write), 32'd1);
        t.size = 2'd0; t.lsb = 2'd3; t.zext = 1; drive(t); cycle();
        check("lbu_lane3", bus.o_wb_data_write, 32'h00000080);
        t.size = 2'd1; t.lsb = 2'd2; t.zext = 0; drive(t); cycle();
        check("lh_lane2", bus.o_wb_data_write, 32'hFFFF80FF);
        t.size = 2'd1; t.lsb = 2'd3; t.zext = 1; drive(t); cycle();
        check("lhu_lsb3", bus.o_wb_data_write, 32'h000080FF);
        t.size = 2'd2; t.lsb = 2'd1; t.zext = 0; drive(t); cycle();
        check("lw_size10", bus.o_wb_data_write, 32'h80FF7F01);

        // LUI
        t = nop; t.valid = 1; t.reg_write = 1; t.lui = 1; t.ext = 32'h00001234; t.dst = 5'd4;
        t.alu = 32'hDEAD; drive(t);
        check("lui_not_yet", bus.o_wb_data_write, 32'h80FF7F01);
        cycle();
        check("lui_data", bus.o_wb_data_write, 32'h12340000);
        check("lui_addr", 32'(bus.o_wb_register_adrr_result), 32'd4);

        // JAL / JALR
        t = nop; t.valid = 1; t.jal = 1; t.pc8 = 32'h108; t.dst = 5'd7; t.alu = 32'h55; drive(t); cycle();
        check("jal_data", bus.o_wb_data_write, 32'h108);
        check("jal_addr", 32'(bus.o_wb_register_adrr_result), 32'd31);
        check("jal_ex", bus.o_wb_data_write_ex, 32'h55);
        check("jal_we", 32'(bus.o_wb_reg_write), 32'd1);
        t.jal = 0; t.jalr = 1; drive(t); cycle();
        check("jalr_addr", 32'(bus.o_wb_register_adrr_result), 32'd7);
        check("jalr_data", bus.o_wb_data_write, 32'h108);
        check("count_8", bus.o_retired_count, 32'd8);

        // Stall: A, B, then C held off for two cycles
        t = nop; t.valid = 1; t.reg_write = 1; t.alu = 32'h11; t.dst = 5'd5; drive(t); cycle();
        t.alu = 32'h22; t.dst = 5'd6; drive(t); cycle();
        t.alu = 32'h33; t.dst = 5'd8; drive(t); bus.i_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("stall_data", bus.o_wb_data_write, 32'h22);
            check("stall_we", 32'(bus.o_wb_reg_write), 32'd1);
            check("stall_count", bus.o_retired_count, 32'd10);
        end
        bus.i_stall = 1'b0; cycle();
        check("after_stall_data", bus.o_wb_data_write, 32'h33);
        check("count_11", bus.o_retired_count, 32'd11);

        // Flush, then flush together with stall
        t.alu = 32'h44; t.dst = 5'd9; drive(t); bus.i_flush = 1'b1; cycle();
        check("flush_we", 32'(bus.o_wb_reg_write), 32'd0);
        check("flush_count", bus.o_retired_count, 32'd11);
        bus.i_stall = 1'b1; cycle();
        check("flush_stall_we", 32'(bus.o_wb_reg_write), 32'd0);
        check("flush_stall_count", bus.o_retired_count, 32'd11);
        bus.i_flush = 1'b0; bus.i_stall = 1'b0;

        // Write to $0
        t = nop; t.valid = 1; t.reg_write = 1; t.alu = 32'h99; t.dst = 5'd0; drive(t); cycle();
        check("r0_we", 32'(bus.o_wb_reg_write), 32'd0);
        check("r0_count", bus.o_retired_count, 32'd12);

        // HALT followed by two valid instructions
        t = nop; t.valid = 1; t.halt = 1; drive(t); cycle();
        check("halt_count", bus.o_retired_count, 32'd13);
        check("halt_not_yet", 32'(bus.o_halted), 32'd0);
        t = nop; t.valid = 1; t.reg_write = 1; t.alu = 32'h77; t.dst = 5'd9; drive(t);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("halted_flag", 32'(bus.o_halted), 32'd1);
            check("halted_count", bus.o_retired_count, 32'd13);
            check("halted_we", 32'(bus.o_wb_reg_write), 32'd0);
        end

        // Reset while HALTED
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_halt_flag", 32'(bus.o_halted), 32'd0);
        check("rst_halt_count", bus.o_retired_count, 32'd0);
        cycle();
        check("resume_data", bus.o_wb_data_write, 32'h77);
        check("resume_count", bus.o_retired_count, 32'd1);

        // Reset during a stall
        bus.i_stall = 1'b1; rst = 1'b1; cycle(); rst = 1'b0; bus.i_stall = 1'b0;
        check("rst_stall_we", 32'(bus.o_wb_reg_write), 32'd0);
        check("rst_stall_data", bus.o_wb_data_write, 32'd0);
        check("rst_stall_count", bus.o_retired_count, 32'd0);

        drive(nop); cycle();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
